// File: rtl/rr_mux_arbiter4_if.sv
// Request/grant bus shared by rr_mux_arbiter4 and its four requesters.
// grant_cnt is present only when GRANT_COUNT_EN is defined.
interface rr_mux_arbiter4_if #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [3:0]    req;
  logic [3:0]    grant;
  logic [1:0]    sel;
  logic          valid;
  logic [HW-1:0] hold_cnt;
`ifdef GRANT_COUNT_EN
  logic [4*CNT_W-1:0] grant_cnt;

  modport master (input req, output grant, sel, valid, hold_cnt, grant_cnt);
  modport slave  (output req, input grant, sel, valid, hold_cnt, grant_cnt);
`else
  modport master (input req, output grant, sel, valid, hold_cnt);
  modport slave  (output req, input grant, sel, valid, hold_cnt);
`endif
endinterface

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter for a shared 4-way mux, with bounded hold per grant.
// Optional per-requester grant counters are enabled by defining GRANT_COUNT_EN.
module rr_mux_arbiter4 #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  rr_mux_arbiter4_if.master  bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [1:0]    last;
  logic [3:0]    grant_q;
  logic [1:0]    sel_q;
  logic          valid_q;
  logic [HW-1:0] hold_q;

  logic [1:0]    base;
  logic [1:0]    idx;
  logic [1:0]    win;
  logic          win_found;
  logic          release_ev;
  logic          new_grant;

  // In GRANT the owner is the scan base, so it is visited last and only wins alone.
  always_comb begin
    base      = (state == GRANT) ? sel_q : last;
    win_found = 1'b0;
    win       = base;
    idx       = base;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
    release_ev = !bus.req[sel_q] || (hold_q == HW'(MAX_HOLD));
    new_grant  = win_found && ((state == IDLE) || release_ev);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 2'd3;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state   <= GRANT;
            grant_q <= 4'b0001 << win;
            sel_q   <= win;
            valid_q <= 1'b1;
            hold_q  <= HW'(1);
          end
        end
        GRANT: begin
          if (!release_ev) begin
            hold_q <= hold_q + HW'(1);
          end else begin
            last <= sel_q;
            if (win_found) begin
              grant_q <= 4'b0001 << win;
              sel_q   <= win;
              valid_q <= 1'b1;
              hold_q  <= HW'(1);
            end else begin
              state   <= IDLE;
              grant_q <= '0;
              valid_q <= 1'b0;
              hold_q  <= '0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.valid    = valid_q;
  assign bus.hold_cnt = hold_q;

`ifdef GRANT_COUNT_EN
  logic [CNT_W-1:0]   cnt_q [4];
  logic [4*CNT_W-1:0] cnt_flat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (new_grant && (cnt_q[win] != '1)) begin
      cnt_q[win] <= cnt_q[win] + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int unsigned i = 0; i < 4; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign bus.grant_cnt = cnt_flat;
`endif

  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
  a_valid:  assert property (@(posedge clk) disable iff (reset) valid_q == (|grant_q));
  a_sel:    assert property (@(posedge clk) disable iff (reset) valid_q |-> grant_q[sel_q]);
endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Scoreboard bench for rr_mux_arbiter4: MAX_HOLD=4 instance plus a MAX_HOLD=1, CNT_W=4 instance.
module tb_rr_mux_arbiter4;
  typedef struct {
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic        valid;
    logic [31:0] hold;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_a = '0;
  logic [3:0] req_b = '0;
  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       qa[$];
  exp_t       qb[$];
  exp_t       ea, eb;

  always #5 clk = ~clk;

  rr_mux_arbiter4_if #(.MAX_HOLD(4), .CNT_W(8)) ifa ();
  rr_mux_arbiter4_if #(.MAX_HOLD(1), .CNT_W(4)) ifb ();
  assign ifa.req = req_a;
  assign ifb.req = req_b;

  rr_mux_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  rr_mux_arbiter4 #(.MAX_HOLD(1), .CNT_W(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step_a(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                        input logic v, input int h, input string nm);
    exp_t e;
    @(negedge clk);
    req_a = r;
    e.grant = g; e.sel = s; e.valid = v; e.hold = h; e.cnt = '0; e.name = nm;
    qa.push_back(e);
  endtask

  task automatic step_b(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                        input logic v, input int h, input logic [3:0] c1, input logic [3:0] c0,
                        input string nm);
    exp_t e;
    @(negedge clk);
    req_b = r;
    e.grant = g; e.sel = s; e.valid = v; e.hold = h; e.cnt = {8'h00, c1, c0}; e.name = nm;
    qb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk({ea.name, ".grant"}, 32'(ifa.grant), 32'(ea.grant));
      chk({ea.name, ".sel"},   32'(ifa.sel),   32'(ea.sel));
      chk({ea.name, ".valid"}, 32'(ifa.valid), 32'(ea.valid));
      chk({ea.name, ".hold"},  32'(ifa.hold_cnt), ea.hold);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk({eb.name, ".grant"}, 32'(ifb.grant), 32'(eb.grant));
      chk({eb.name, ".sel"},   32'(ifb.sel),   32'(eb.sel));
      chk({eb.name, ".valid"}, 32'(ifb.valid), 32'(eb.valid));
      chk({eb.name, ".hold"},  32'(ifb.hold_cnt), eb.hold);
`ifdef GRANT_COUNT_EN
      chk({eb.name, ".grant_cnt"}, 32'(ifb.grant_cnt), 32'(eb.cnt));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1;
    req_a = 4'b1111;
    #12;
    chk("rst.grant", 32'(ifa.grant), 32'h0);
    chk("rst.sel",   32'(ifa.sel),   32'h0);
    chk("rst.valid", 32'(ifa.valid), 32'h0);
    chk("rst.hold",  32'(ifa.hold_cnt), 32'h0);

    // Release reset on the same negedge as the first expectation
    step_a(4'b1111, 4'b0001, 2'd0, 1'b1, 1, "rst_release");
    reset = 1'b0;
    for (int k = 1; k < 20; k++)
      step_a(4'b1111, 4'(1 << ((k / 4) % 4)), 2'((k / 4) % 4), 1'b1, k % 4 + 1, "rotate");

    step_a(4'b0100, 4'b0100, 2'd2, 1'b1, 1, "single_h1");
    step_a(4'b0100, 4'b0100, 2'd2, 1'b1, 2, "single_h2");
    step_a(4'b0100, 4'b0100, 2'd2, 1'b1, 3, "single_h3");
    step_a(4'b0100, 4'b0100, 2'd2, 1'b1, 4, "single_h4");
    step_a(4'b0100, 4'b0100, 2'd2, 1'b1, 1, "single_regrant");
    step_a(4'b0100, 4'b0100, 2'd2, 1'b1, 2, "single_h2b");

    @(posedge clk);
    #3;
    reset = 1'b1;
    req_a = 4'b0000;
    #1;
    chk("midrst.grant", 32'(ifa.grant), 32'h0);
    chk("midrst.sel",   32'(ifa.sel),   32'h0);
    chk("midrst.valid", 32'(ifa.valid), 32'h0);
    chk("midrst.hold",  32'(ifa.hold_cnt), 32'h0);
    step_a(4'b1101, 4'b0001, 2'd0, 1'b1, 1, "after_rst_prio0");
    reset = 1'b0;

    step_a(4'b0010, 4'b0010, 2'd1, 1'b1, 1, "drop_to_1");
    step_a(4'b0010, 4'b0010, 2'd1, 1'b1, 2, "own1_h2");
    step_a(4'b1000, 4'b1000, 2'd3, 1'b1, 1, "switch_1_to_3");
    step_a(4'b0000, 4'b0000, 2'd3, 1'b0, 0, "to_idle");
    step_a(4'b0000, 4'b0000, 2'd3, 1'b0, 0, "idle_sel_hold");
    begin
      exp_t e;
      @(negedge clk);
      req_a = 4'b0100;
      #2 req_a = 4'b0000;
      e.grant = 4'b0000; e.sel = 2'd3; e.valid = 1'b0; e.hold = 0; e.cnt = '0; e.name = "pulse_ignored";
      qa.push_back(e);
    end
    step_a(4'b0001, 4'b0001, 2'd0, 1'b1, 1, "idle_to_0");
    step_a(4'b0000, 4'b0000, 2'd0, 1'b0, 0, "idle_end");

    for (int k = 1; k <= 17; k++) begin
      c0 = (k > 15) ? 15 : k;
      step_b(4'b0001, 4'b0001, 2'd0, 1'b1, 1, 4'd0, 4'(c0), "mh1_regrant");
    end
    step_b(4'b0011, 4'b0010, 2'd1, 1'b1, 1, 4'd1, 4'd15, "mh1_alt1");
    step_b(4'b0011, 4'b0001, 2'd0, 1'b1, 1, 4'd1, 4'd15, "mh1_alt0");
    step_b(4'b0011, 4'b0010, 2'd1, 1'b1, 1, 4'd2, 4'd15, "mh1_alt1b");
    step_b(4'b0011, 4'b0001, 2'd0, 1'b1, 1, 4'd2, 4'd15, "mh1_alt0b");
    step_b(4'b0000, 4'b0000, 2'd0, 1'b0, 0, 4'd2, 4'd15, "mh1_idle");

    repeat (3) @(negedge clk);
    chk("queue_a_drained", 32'(qa.size()), 32'h0);
    chk("queue_b_drained", 32'(qb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
